// File: rtl/hier_tree_node_if.sv
`default_nettype none
// ==================================================================
// hier_tree_node_if : parent/child handshake bundle of one tree node.
// Rev 1.0
// ==================================================================
interface hier_tree_node_if #(
   parameter int N_CHILD = 5,
   parameter int TMO_W   = 16
);
   localparam int CW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

   logic               start_i;
   logic [TMO_W-1:0]   tmo_limit_i;
   logic [N_CHILD-1:0] child_start_o;
   logic [N_CHILD-1:0] child_done_i;
   logic               busy_o;
   logic               done_o;
   logic               err_o;
   logic [N_CHILD-1:0] done_mask_o;
   logic [CW-1:0]      cur_child_o;

   modport slave (
      input  start_i, tmo_limit_i, child_done_i,
      output child_start_o, busy_o, done_o, err_o, done_mask_o, cur_child_o
   );

   modport master (
      output start_i, tmo_limit_i, child_done_i,
      input  child_start_o, busy_o, done_o, err_o, done_mask_o, cur_child_o
   );
endinterface
`default_nettype wire

// File: rtl/hier_tree_node.sv
`default_nettype none
// ==================================================================
// hier_tree_node : sequenced tree node, launches children in parallel or
// in order, collects dones under a per-phase timeout. Rev 1.0
// ==================================================================
module hier_tree_node #(
   parameter int N_CHILD  = 5,
   parameter int MODE_SEQ = 0,
   parameter int TMO_W    = 16
) (
   input  logic            clk,
   input  logic            rst,
   hier_tree_node_if.slave bus
);
   localparam int CW = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_FIN    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [TMO_W-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]      idx_q, idx_d;
   logic [N_CHILD-1:0] mask_q, mask_d;
   logic               err_q, err_d;

   logic [N_CHILD-1:0] w_cap;
   logic [N_CHILD-1:0] w_start;
   logic               w_complete;
   logic               w_last;
   logic               w_tmo;

   if (MODE_SEQ != 0) begin : g_seq
      logic [N_CHILD-1:0] w_onehot;
      // Only the child currently served may contribute to the mask.
      assign w_onehot   = N_CHILD'(1) << idx_q;
      assign w_cap      = bus.child_done_i & w_onehot;
      assign w_complete = |((mask_q | w_cap) & w_onehot);
      assign w_start    = w_onehot;
      assign w_last     = (idx_q == CW'(N_CHILD - 1));
   end else begin : g_par
      assign w_cap      = bus.child_done_i;
      assign w_complete = &(mask_q | w_cap);
      assign w_start    = '1;
      assign w_last     = 1'b1;
   end

   assign w_tmo = (bus.tmo_limit_i != '0) && (cnt_q == bus.tmo_limit_i - TMO_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         mask_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               mask_d  = '0;
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d  = '0;
            mask_d = mask_q | w_cap;
            // A child may answer in its own launch cycle; no wait phase then.
            if (w_complete) begin
               if (w_last) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + CW'(1);
                  state_d = S_LAUNCH;
               end
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            mask_d = mask_q | w_cap;
            if (cnt_q != '1) begin
               cnt_d = cnt_q + TMO_W'(1);
            end
            if (w_complete) begin
               if (w_last) begin
                  state_d = S_FIN;
               end else begin
                  idx_d   = idx_q + CW'(1);
                  state_d = S_LAUNCH;
               end
            end else if (w_tmo) begin
               err_d   = 1'b1;
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.child_start_o = (state_q == S_LAUNCH) ? w_start : '0;
   assign bus.busy_o        = (state_q != S_IDLE);
   assign bus.done_o        = (state_q == S_FIN);
   assign bus.err_o         = err_q;
   assign bus.done_mask_o   = mask_q;
   assign bus.cur_child_o   = idx_q;
endmodule
`default_nettype wire

// File: tb/tb_hier_tree_node.sv
`default_nettype none
// ==================================================================
// tb_hier_tree_node : parallel (5 children) and sequential (3 children)
// nodes checked against a run-level timing model. Rev 1.0
// ==================================================================
module tb_hier_tree_node;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   hier_tree_node_if #(.N_CHILD(5), .TMO_W(16)) pif ();
   hier_tree_node_if #(.N_CHILD(3), .TMO_W(16)) sif ();

   hier_tree_node #(.N_CHILD(5), .MODE_SEQ(0), .TMO_W(16)) u_par (.clk(clk), .rst(rst), .bus(pif));
   hier_tree_node #(.N_CHILD(3), .MODE_SEQ(1), .TMO_W(16)) u_seq (.clk(clk), .rst(rst), .bus(sif));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // d[i] = cycle offset of child i's done pulse after start (offset 0), -1 = silent
   task automatic run_par(input int d[5], input int tmo, input bit hold);
      int cmax, tcut, edone, got, ndone, lbad, bbad;
      bit all;
      logic       eerr, gerr;
      logic [4:0] emask, gmask, cd, clr;
      all = 1'b1; cmax = 1; tcut = tmo + 1;
      for (int i = 0; i < 5; i++) begin
         if (d[i] < 0) all = 1'b0;
         else if (d[i] > cmax) cmax = d[i];
      end
      if (all && (tmo == 0 || cmax <= tcut)) begin
         edone = cmax + 1; eerr = 1'b0; emask = 5'h1F;
      end else begin
         edone = tcut + 1; eerr = 1'b1; emask = '0;
         for (int i = 0; i < 5; i++) if (d[i] >= 1 && d[i] <= tcut) emask[i] = 1'b1;
      end
      got = -1; ndone = 0; lbad = 0; bbad = 0; gerr = 1'bx; gmask = 'x; clr = 'x;
      pif.tmo_limit_i = 16'(tmo);
      for (int k = 0; k <= edone + 3; k++) begin
         pif.start_i = (k == 0) || (hold && k <= edone);
         cd = '0;
         for (int i = 0; i < 5; i++) if (d[i] == k) cd[i] = 1'b1;
         pif.child_done_i = cd;
         @(negedge clk);
         if (pif.child_start_o !== ((k == 1) ? 5'h1F : 5'h00)) lbad++;
         if (pif.cur_child_o !== 3'd0) lbad++;
         if (pif.busy_o !== (k >= 1 && k <= edone)) bbad++;
         if (k == 1) clr = {pif.err_o, pif.done_mask_o[3:0]} | {4'd0, pif.done_mask_o[4]};
         if (pif.done_o === 1'b1) begin
            ndone++;
            if (got < 0) begin got = k; gerr = pif.err_o; gmask = pif.done_mask_o; end
         end
         @(posedge clk); #1;
      end
      pif.start_i = 1'b0; pif.child_done_i = '0;
      chk("par_clear_on_start", clr, 5'd0);
      chk("par_done_cycle", got, edone);
      chk("par_done_count", ndone, 1);
      chk("par_err", gerr, eerr);
      chk("par_mask", gmask, emask);
      chk("par_launch", lbad, 0);
      chk("par_busy", bbad, 0);
      chk("par_hold", {pif.err_o, pif.done_mask_o}, {eerr, emask});
   endtask

   // r[k] = delay of child k's done after its own launch, -1 = silent
   task automatic run_seq(input int r[3], input int tmo, input bit stray);
      int lnch, cfin, last, edone, got, ndone, lbad;
      int pat[3];
      int lc[3];
      logic       eerr, gerr;
      logic [2:0] emask, gmask, cd, el;
      logic [1:0] gcur;
      lnch = 1; cfin = 1; last = 0; eerr = 1'b0; emask = '0;
      pat = '{-1, -1, -1}; lc = '{-1, -1, -1};
      for (int k = 0; k < 3; k++) begin
         last = k; lc[k] = lnch;
         if (r[k] >= 0) pat[k] = lnch + r[k];
         if (r[k] >= 0 && (tmo == 0 || r[k] <= tmo)) begin
            emask[k] = 1'b1; cfin = lnch + r[k]; lnch = cfin + 1;
         end else begin
            eerr = 1'b1; cfin = lnch + tmo;
            break;
         end
      end
      edone = cfin + 1;
      got = -1; ndone = 0; lbad = 0; gerr = 1'bx; gmask = 'x; gcur = 'x;
      sif.tmo_limit_i = 16'(tmo);
      for (int k = 0; k <= edone + 2; k++) begin
         sif.start_i = (k == 0);
         cd = '0;
         for (int i = 0; i < 3; i++) if (pat[i] == k) cd[i] = 1'b1;
         if (stray && k == 2) cd[2] = 1'b1;
         sif.child_done_i = cd;
         el = '0;
         for (int i = 0; i < 3; i++) if (lc[i] == k) el[i] = 1'b1;
         @(negedge clk);
         if (sif.child_start_o !== el) lbad++;
         if (sif.done_o === 1'b1) begin
            ndone++;
            if (got < 0) begin got = k; gerr = sif.err_o; gmask = sif.done_mask_o; gcur = sif.cur_child_o; end
         end
         @(posedge clk); #1;
      end
      sif.start_i = 1'b0; sif.child_done_i = '0;
      chk("seq_done_cycle", got, edone);
      chk("seq_done_count", ndone, 1);
      chk("seq_err", gerr, eerr);
      chk("seq_mask", gmask, emask);
      chk("seq_cur_child", gcur, last);
      chk("seq_launch", lbad, 0);
   endtask

   initial begin
      int d[5];
      int r[3];
      int tmo, nd;
      pif.start_i = 1'b0; pif.tmo_limit_i = '0; pif.child_done_i = '0;
      sif.start_i = 1'b0; sif.tmo_limit_i = '0; sif.child_done_i = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_par", {pif.busy_o, pif.done_o, pif.err_o, pif.done_mask_o, pif.child_start_o, pif.cur_child_o}, 0);
      chk("reset_seq", {sif.busy_o, sif.done_o, sif.err_o, sif.done_mask_o, sif.child_start_o, sif.cur_child_o}, 0);
      @(posedge clk); #1;

      run_par('{3, 4, 5, 6, 7}, 0, 1'b0);
      run_seq('{2, 2, 2}, 0, 1'b0);
      run_par('{1, 2, -1, 3, 4}, 4, 1'b0);
      run_par('{3, 4, 5, 6, 7}, 0, 1'b0);
      run_par('{1, 2, 5, 3, 4}, 4, 1'b0);
      run_par('{1, 1, 1, 1, 1}, 0, 1'b0);
      run_par('{2, 5, 3, 4, 2}, 0, 1'b1);
      run_seq('{3, -1, 1}, 3, 1'b1);
      run_seq('{0, 0, 0}, 1, 1'b0);

      // abort mid-WAIT with reset
      pif.tmo_limit_i = '0; pif.start_i = 1'b1;
      @(posedge clk); #1;
      pif.start_i = 1'b0; pif.child_done_i = 5'h03;
      @(posedge clk); #1;
      pif.child_done_i = '0;
      @(posedge clk); #1;
      chk("mid_wait_state", {pif.busy_o, pif.done_mask_o}, {1'b1, 5'h03});
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {pif.busy_o, pif.done_o, pif.err_o, pif.done_mask_o, pif.child_start_o, pif.cur_child_o}, 0);
      @(posedge clk); #1 rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (pif.done_o !== 1'b0 || pif.busy_o !== 1'b0) nd++;
         @(posedge clk); #1;
      end
      chk("rst_no_done", nd, 0);
      run_par('{3, 4, 5, 6, 7}, 0, 1'b0);

      for (int n = 0; n < 8; n++) begin
         tmo = $urandom_range(0, 10);
         for (int i = 0; i < 5; i++)
            d[i] = (tmo != 0 && $urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 9));
         run_par(d, tmo, 1'($urandom_range(0, 1)));
      end
      for (int n = 0; n < 8; n++) begin
         tmo = $urandom_range(0, 6);
         for (int i = 0; i < 3; i++)
            r[i] = (tmo != 0 && $urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
         run_seq(r, tmo, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
